quiz_round_ctrl: RTL and testbench

Clocked, parametrised round controller for the multi-player reaction quiz. Sequences through a fixed number of questions, arbitrates the first valid joystick press among N players, judges it against the current answer, keeps saturating per-player scores, and declares a winner at end of game. Sits between the joystick pads and the question table and display drivers; the question table supplies `ans` for the current `q_idx`.

---
 rtl/quiz_round_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_quiz_round_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quiz_round_ctrl.sv
// quiz_round_ctrl: question sequencer, first-press arbiter, answer judge and score keeper.
// Optional feature macro QUIZ_PENALTY_EN: a wrong answer also costs one point (floor 0).
module quiz_round_ctrl #(
    parameter int NUM_PLAYERS   = 2,
    parameter int NUM_QUESTIONS = 5,
    parameter int SCORE_MAX     = 5,
    parameter int SHOW_CYCLES   = 4,
    localparam int PW = $clog2(NUM_PLAYERS),
    localparam int QW = $clog2(NUM_QUESTIONS),
    localparam int SW = $clog2(SCORE_MAX + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [4*NUM_PLAYERS-1:0]    joy_in,
    input  logic [1:0]                  ans,
    output logic [QW-1:0]               q_idx,
    output logic                        q_valid,
    output logic [SW*NUM_PLAYERS-1:0]   scores,
    output logic [NUM_PLAYERS-1:0]      lockout,
    output logic                        result_valid,
    output logic [PW-1:0]               result_player,
    output logic                        result_correct,
    output logic                        game_done,
    output logic [PW-1:0]               winner,
    output logic                        winner_tie
);
    localparam int CW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ASK, S_JUDGE, S_SHOW, S_DONE} state_e;

    state_e                             state_q, state_d;
    logic [QW-1:0]                      q_idx_q, q_idx_d;
    logic [NUM_PLAYERS-1:0][SW-1:0]     score_q, score_d;
    logic [NUM_PLAYERS-1:0]             lock_q, lock_d;
    logic [4*NUM_PLAYERS-1:0]           joy_prev_q;
    logic [PW-1:0]                      player_q, player_d;
    logic                               correct_q, correct_d;
    logic [CW-1:0]                      cnt_q, cnt_d;
    logic                               q_valid_q, result_valid_q, game_done_q;
    logic [PW-1:0]                      winner_q;
    logic                               tie_q;

    logic                               press_hit_s;
    logic [PW-1:0]                      press_player_s;
    logic [1:0]                         press_choice_s;
    logic [SW-1:0]                      best_s;
    logic [PW-1:0]                      win_s;
    logic                               tie_s;

    function automatic logic [1:0] enc_choice(input logic [3:0] grp);
        case (grp)
            4'b0001: enc_choice = 2'd0;
            4'b0010: enc_choice = 2'd1;
            4'b0100: enc_choice = 2'd2;
            4'b1000: enc_choice = 2'd3;
            default: enc_choice = 2'd0;
        endcase
    endfunction

    // Clean rising-edge press per player; scanning downward leaves the lowest index as winner.
    always_comb begin
        press_hit_s    = 1'b0;
        press_player_s = '0;
        press_choice_s = 2'd0;
        for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
            if ((joy_prev_q[4*p +: 4] == 4'b0000) && $onehot(joy_in[4*p +: 4]) && !lock_q[p]) begin
                press_hit_s    = 1'b1;
                press_player_s = PW'(p);
                press_choice_s = enc_choice(joy_in[4*p +: 4]);
            end else begin
                press_hit_s    = press_hit_s;
            end
        end
    end

    // Top score search; strict '>' keeps the lowest index on a tie.
    always_comb begin
        best_s = score_q[0];
        win_s  = '0;
        tie_s  = 1'b0;
        for (int p = 1; p < NUM_PLAYERS; p++) begin
            if (score_q[p] > best_s) begin
                best_s = score_q[p];
                win_s  = PW'(p);
                tie_s  = 1'b0;
            end else if (score_q[p] == best_s) begin
                tie_s  = 1'b1;
            end else begin
                tie_s  = tie_s;
            end
        end
    end

    // Round sequencing, judging and scoring.
    always_comb begin
        state_d   = state_q;
        q_idx_d   = q_idx_q;
        score_d   = score_q;
        lock_d    = lock_q;
        player_d  = player_q;
        correct_d = correct_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_ASK;
                    q_idx_d = '0;
                    score_d = '0;
                    lock_d  = '0;
                end else begin
                    state_d = state_q;
                end
            end
            S_ASK: begin
                if (press_hit_s) begin
                    state_d   = S_JUDGE;
                    player_d  = press_player_s;
                    correct_d = (press_choice_s == ans);
                end else begin
                    state_d   = S_ASK;
                end
            end
            S_JUDGE: begin
                if (correct_q) begin
                    if (score_q[player_q] != SW'(SCORE_MAX)) begin
                        score_d[player_q] = score_q[player_q] + 1'b1;
                    end else begin
                        score_d[player_q] = score_q[player_q];
                    end
                end else begin
                    lock_d[player_q] = 1'b1;
`ifdef QUIZ_PENALTY_EN
                    if (score_q[player_q] != '0) begin
                        score_d[player_q] = score_q[player_q] - 1'b1;
                    end else begin
                        score_d[player_q] = score_q[player_q];
                    end
`else
                    score_d[player_q] = score_q[player_q];
`endif
                end
                cnt_d   = '0;
                state_d = S_SHOW;
            end
            S_SHOW: begin
                if (cnt_q == CW'(SHOW_CYCLES - 1)) begin
                    // Judge has already updated lock_q, so &lock_q includes this answer.
                    if (correct_q || (&lock_q)) begin
                        if (q_idx_q == QW'(NUM_QUESTIONS - 1)) begin
                            state_d = S_DONE;
                        end else begin
                            q_idx_d = q_idx_q + 1'b1;
                            lock_d  = '0;
                            state_d = S_ASK;
                        end
                    end else begin
                        state_d = S_ASK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            q_idx_q        <= '0;
            score_q        <= '0;
            lock_q         <= '0;
            joy_prev_q     <= '0;
            player_q       <= '0;
            correct_q      <= 1'b0;
            cnt_q          <= '0;
            q_valid_q      <= 1'b0;
            result_valid_q <= 1'b0;
            game_done_q    <= 1'b0;
            winner_q       <= '0;
            tie_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            q_idx_q        <= q_idx_d;
            score_q        <= score_d;
            lock_q         <= lock_d;
            joy_prev_q     <= joy_in;
            player_q       <= player_d;
            correct_q      <= correct_d;
            cnt_q          <= cnt_d;
            q_valid_q      <= (state_d == S_ASK);
            result_valid_q <= (state_d == S_SHOW);
            game_done_q    <= (state_d == S_DONE);
            winner_q       <= (state_d == S_DONE) ? win_s : '0;
            tie_q          <= (state_d == S_DONE) ? tie_s : 1'b0;
        end
    end

    assign q_idx          = q_idx_q;
    assign q_valid        = q_valid_q;
    assign scores         = score_q;
    assign lockout        = lock_q;
    assign result_valid   = result_valid_q;
    assign result_player  = player_q;
    assign result_correct = correct_q;
    assign game_done      = game_done_q;
    assign winner         = winner_q;
    assign winner_tie     = tie_q;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Bench for quiz_round_ctrl: directed vector table, corner sequences and a random run vs. a game model.
module tb_quiz_round_ctrl;
    localparam int NP    = 2;
    localparam int NQ    = 8;
    localparam int SMAX  = 5;
    localparam int SHOWC = 4;
    localparam int PW    = $clog2(NP);
    localparam int QW    = $clog2(NQ);
    localparam int SW    = $clog2(SMAX + 1);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [4*NP-1:0]      joy = '0;
    logic [1:0]           ans = 2'd0;
    logic [QW-1:0]        q_idx;
    logic                 q_valid;
    logic [SW*NP-1:0]     scores;
    logic [NP-1:0]        lockout;
    logic                 result_valid;
    logic [PW-1:0]        result_player;
    logic                 result_correct;
    logic                 game_done;
    logic [PW-1:0]        winner;
    logic                 winner_tie;

    int checks = 0;
    int errors = 0;

    quiz_round_ctrl #(.NUM_PLAYERS(NP), .NUM_QUESTIONS(NQ), .SCORE_MAX(SMAX), .SHOW_CYCLES(SHOWC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .joy_in(joy), .ans(ans),
        .q_idx(q_idx), .q_valid(q_valid), .scores(scores), .lockout(lockout),
        .result_valid(result_valid), .result_player(result_player), .result_correct(result_correct),
        .game_done(game_done), .winner(winner), .winner_tie(winner_tie)
    );

    always #5 clk = ~clk;

    // Game model: phase flags plus plain integer scores.
    bit          m_ask, m_judge, m_done;
    int          m_show, m_q, m_player;
    bit          m_correct;
    int          m_score [NP];
    logic [NP-1:0]   m_lock;
    logic [4*NP-1:0] m_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ask = 0; m_judge = 0; m_done = 0; m_show = 0; m_q = 0; m_player = 0; m_correct = 0;
        for (int p = 0; p < NP; p++) m_score[p] = 0;
        m_lock = '0; m_prev = '0;
    endtask

    task automatic model_tick();
        logic [3:0] g;
        bit found;
        found = 0;
        if (m_show > 0) begin
            m_show--;
            if (m_show == 0) begin
                if (m_correct || (m_lock == {NP{1'b1}})) begin
                    if (m_q == NQ - 1) m_done = 1;
                    else begin m_q++; m_lock = '0; m_ask = 1; end
                end else m_ask = 1;
            end
        end else if (m_judge) begin
            m_judge = 0;
            m_show = SHOWC;
            if (m_correct) m_score[m_player] = (m_score[m_player] + 1 > SMAX) ? SMAX : m_score[m_player] + 1;
            else begin
                m_lock[m_player] = 1'b1;
`ifdef QUIZ_PENALTY_EN
                m_score[m_player] = (m_score[m_player] > 0) ? m_score[m_player] - 1 : 0;
`endif
            end
        end else if (m_ask) begin
            for (int p = 0; p < NP; p++) begin
                g = joy[4*p +: 4];
                if (!found && m_prev[4*p +: 4] == 4'b0000 && $countones(g) == 1 && !m_lock[p]) begin
                    found = 1;
                    m_player = p;
                    for (int k = 0; k < 4; k++) if (g[k]) m_correct = (k == int'(ans));
                end
            end
            if (found) begin m_ask = 0; m_judge = 1; end
        end else if (start) begin
            m_done = 0; m_ask = 1; m_q = 0; m_lock = '0;
            for (int p = 0; p < NP; p++) m_score[p] = 0;
        end
        m_prev = joy;
    endtask

    function automatic logic [SW*NP-1:0] exp_scores();
        logic [SW*NP-1:0] r;
        r = '0;
        for (int p = 0; p < NP; p++) r[SW*p +: SW] = SW'(m_score[p]);
        return r;
    endfunction

    task automatic compare_all();
        int best, w, cnt;
        chk("q_valid", q_valid, m_ask);
        chk("q_idx", q_idx, m_q);
        chk("result_valid", result_valid, m_show > 0);
        chk("game_done", game_done, m_done);
        chk("scores", scores, exp_scores());
        chk("lockout", lockout, m_lock);
        if (m_judge || m_show > 0) begin
            chk("result_player", result_player, m_player);
            chk("result_correct", result_correct, m_correct);
        end
        if (m_done) begin
            best = -1; w = 0; cnt = 0;
            for (int p = 0; p < NP; p++) if (m_score[p] > best) begin best = m_score[p]; w = p; end
            for (int p = 0; p < NP; p++) if (m_score[p] == best) cnt++;
            chk("winner", winner, w);
            chk("winner_tie", winner_tie, cnt > 1);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_tick();
        #1;
        compare_all();
    endtask

    task automatic press(input int p, input int ch);
        joy = '0;
        joy[4*p +: 4] = 4'b0001 << ch;
        step();
        joy = '0;
        for (int i = 0; i < 20 && (m_judge || m_show > 0); i++) step();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_q_idx"}, q_idx, 0);
        chk({tag, "_q_valid"}, q_valid, 0);
        chk({tag, "_scores"}, scores, 0);
        chk({tag, "_lockout"}, lockout, 0);
        chk({tag, "_result_valid"}, result_valid, 0);
        chk({tag, "_result_player"}, result_player, 0);
        chk({tag, "_result_correct"}, result_correct, 0);
        chk({tag, "_game_done"}, game_done, 0);
        chk({tag, "_winner"}, winner, 0);
        chk({tag, "_winner_tie"}, winner_tie, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; joy = '0; ans = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic       start;
        logic [7:0] joy;
        logic [1:0] ans;
        logic       qv;
        logic [2:0] q;
        logic       rv;
        logic       cr;
        logic       rc;
        logic       rp;
        logic [5:0] sc;
    } vec_t;
    vec_t vecs [15];

    initial begin
        // start, joy, ans | q_valid, q_idx, result_valid, check_result, result_correct, result_player, scores
        vecs[0]  = '{1'b1, 8'h00, 2'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
        vecs[1]  = '{1'b0, 8'h04, 2'd2, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0};
        vecs[2]  = '{1'b0, 8'h04, 2'd2, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd1};
        vecs[3]  = '{1'b0, 8'h00, 2'd2, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd1};
        vecs[4]  = '{1'b0, 8'h00, 2'd2, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd1};
        vecs[5]  = '{1'b0, 8'h00, 2'd2, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd1};
        vecs[6]  = '{1'b0, 8'h00, 2'd0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd1};
        vecs[7]  = '{1'b0, 8'h00, 2'd0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd1};
        vecs[8]  = '{1'b0, 8'h11, 2'd0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 6'd1};
        vecs[9]  = '{1'b0, 8'h00, 2'd0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 6'd2};
        vecs[10] = '{1'b0, 8'h00, 2'd0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 6'd2};
        vecs[11] = '{1'b0, 8'h00, 2'd0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 6'd2};
        vecs[12] = '{1'b0, 8'h00, 2'd0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 6'd2};
        vecs[13] = '{1'b0, 8'h00, 2'd0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 6'd2};
        vecs[14] = '{1'b1, 8'h00, 2'd0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 6'd2};

        do_reset();
        for (int i = 0; i < 15; i++) begin
            start = vecs[i].start; joy = vecs[i].joy; ans = vecs[i].ans;
            @(posedge clk);
            #1;
            chk("vec_q_valid", q_valid, vecs[i].qv);
            chk("vec_q_idx", q_idx, vecs[i].q);
            chk("vec_result_valid", result_valid, vecs[i].rv);
            chk("vec_scores", scores, vecs[i].sc);
            if (vecs[i].cr) begin
                chk("vec_result_correct", result_correct, vecs[i].rc);
                chk("vec_result_player", result_player, vecs[i].rp);
            end
        end

        // Lockout: P1 wrong, P1 retry ignored, P0 wrong closes the question.
        do_reset();
        start = 1'b1; step(); start = 1'b0;
        ans = 2'd3;
        press(1, 1);
        chk("lock_after_p1_wrong", lockout, 2'b10);
        chk("q_idx_same_after_wrong", q_idx, 0);
        press(1, 3);
        chk("locked_p1_ignored", q_valid, 1);
        press(0, 0);
        chk("q_idx_after_all_locked", q_idx, 1);
        chk("lock_cleared_on_advance", lockout, 2'b00);
        chk("p0_wrong_at_zero", scores, 6'd0);

        // Held button across questions, multi-hot and held-over groups.
        ans = 2'd0;
        joy = 8'h01; step();
        for (int i = 0; i < 20 && (m_judge || m_show > 0); i++) step();
        repeat (3) step();
        chk("held_ignored_q_valid", q_valid, 1);
        chk("held_ignored_q_idx", q_idx, 2);
        joy = 8'h00; step();
        joy = 8'h03; step();
        chk("multihot_ignored", q_valid, 1);
        joy = 8'h01; step();
        chk("heldover_ignored", q_valid, 1);
        joy = 8'h00; step();
        press(0, 0);
        chk("clean_press_scored", scores, 6'd2);
        ans = 2'd3;
        press(0, 0);
        chk("lock_p0_wrong", lockout, 2'b01);
`ifdef QUIZ_PENALTY_EN
        chk("penalty_2_to_1", scores, 6'd1);
`else
        chk("no_penalty_stays_2", scores, 6'd2);
`endif

        // Saturation, game end, winner and restart.
        do_reset();
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 7; i++) begin ans = 2'd2; press(0, 2); end
        chk("saturated_score", scores, 6'd5);
        ans = 2'd1;
        press(1, 0);
        press(0, 0);
        chk("game_done_set", game_done, 1);
`ifdef QUIZ_PENALTY_EN
        chk("final_scores", scores, 6'd4);
`else
        chk("final_scores", scores, 6'd5);
`endif
        chk("winner_p0", winner, 0);
        chk("winner_no_tie", winner_tie, 0);
        start = 1'b1; step(); start = 1'b0;
        chk("restart_scores_clear", scores, 6'd0);
        chk("restart_q_valid", q_valid, 1);
        for (int i = 0; i < NQ; i++) begin ans = 2'd2; press(1, 2); end
        chk("winner_p1", winner, 1);
        chk("winner_p1_scores", scores, 6'b101_000);

        // Asynchronous reset in the middle of SHOW.
        start = 1'b1; step(); start = 1'b0;
        ans = 2'd0; joy = 8'h01; step(); joy = 8'h00; step(); step();
        chk("in_show_before_reset", result_valid, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_reset");
        @(posedge clk); #1;
        chk_reset_vals("reset_next_edge");
        rst_n = 1'b1;
        model_reset();

        // Random play against the model.
        for (int c = 0; c < 3000; c++) begin
            if (!m_ask) ans = 2'($urandom);
            start = ($urandom_range(0, 15) == 0);
            for (int p = 0; p < NP; p++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 5) joy[4*p +: 4] = 4'b0000;
                else if (r < 8) joy[4*p +: 4] = 4'b0001 << $urandom_range(0, 3);
                else if (r == 9) joy[4*p +: 4] = 4'($urandom);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
